data_memory_mmio: RTL and testbench

DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

---
 rtl/data_memory_mmio.sv | 130 +++++++++++++
 tb/tb_data_memory_mmio.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: word RAM plus UART RX/TX byte FIFOs and status MMIO behind a stalling core port.
// Define MMIO_CYCLE_COUNTER_EN to build the free-running cycle counter at MMIO offset 3 (reads 0 otherwise).
module data_memory_mmio #(
    parameter int RAM_ADDR_W = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] rd_inst,
    output logic        stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RAM_RD, WAIT_RX, WAIT_TX, DONE} state_t;

    logic [31:0] mem [2**RAM_ADDR_W];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [7:0] tx_mem [FIFO_DEPTH];

    state_t state_q, state_d;
    logic [31:0] rd_q, rd_d, ram_q, cyc;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic req, ram_rd, ram_wr, rx_rd, tx_wr, rx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop, unused_addr;

    // decode the request, FIFO handshakes and combinational outputs; full/empty come from registered counts
    always_comb begin
        ram_idx     = addr[RAM_ADDR_W-1:0];
        unused_addr = ^addr[30:RAM_ADDR_W];
        req         = en && state_q == IDLE;
        ram_rd      = req && !addr[31] && !we;
        ram_wr      = req && !addr[31] && we;
        rx_rd       = req && addr[31] && addr[1:0] == 2'd0 && !we;
        tx_wr       = req && addr[31] && addr[1:0] == 2'd1 && we;
        rx_empty    = rx_cnt_q == '0;
        tx_full     = tx_cnt_q == FULL_CNT;
        rx_ready    = rx_cnt_q != FULL_CNT;
        tx_valid    = !(tx_cnt_q == '0);
        tx_data     = tx_mem[tx_rp_q];
        rx_push     = rx_valid && rx_ready;
        tx_pop      = tx_valid && tx_ready;
        rx_pop      = !rx_empty && (rx_rd || state_q == WAIT_RX);
        tx_push     = !tx_full && (tx_wr || state_q == WAIT_TX);
        stall       = reset && (ram_rd || (rx_rd && rx_empty) || (tx_wr && tx_full)
                                || state_q == WAIT_RX || state_q == WAIT_TX);
        rd          = state_q == RAM_RD ? ram_q : rd_q;
        rd_inst     = !(en && !we && addr[31]) ? '0
                    : addr[1:0] == 2'd2 ? {30'b0, !tx_full, !rx_empty}
                    : addr[1:0] == 2'd3 ? cyc : '0;
    end

    // next-state, read-data latch and FIFO pointer/count arithmetic
    always_comb begin
        state_d  = state_q == RAM_RD || state_q == DONE ? IDLE
                 : state_q == WAIT_RX ? (rx_empty ? WAIT_RX : DONE)
                 : state_q == WAIT_TX ? (tx_full ? WAIT_TX : DONE)
                 : ram_rd ? RAM_RD
                 : rx_rd ? (rx_empty ? WAIT_RX : DONE)
                 : tx_wr && tx_full ? WAIT_TX : IDLE;
        rd_d     = state_q == RAM_RD ? ram_q : rx_pop ? {24'b0, rx_mem[rx_rp_q]} : rd_q;
        rx_wp_d  = rx_wp_q + PW'(rx_push);
        rx_rp_d  = rx_rp_q + PW'(rx_pop);
        tx_wp_d  = tx_wp_q + PW'(tx_push);
        tx_rp_d  = tx_rp_q + PW'(tx_pop);
        rx_cnt_d = rx_cnt_q + (PW+1)'(rx_push) - (PW+1)'(rx_pop);
        tx_cnt_d = tx_cnt_q + (PW+1)'(tx_push) - (PW+1)'(tx_pop);
    end

    // control state, FIFO bookkeeping and latched read data; reset aborts any pending request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // storage arrays carry no reset; the RAM read is registered so it can map onto block RAM
    always_ff @(posedge clock) begin
        if (ram_wr && reset) mem[ram_idx] <= wd;
        ram_q <= mem[ram_idx];
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
        if (tx_push) tx_mem[tx_wp_q] <= wd[7:0];
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q, cyc_d;

    // free-running counter, wraps through zero at 32 bits
    always_comb cyc_d = cyc_q + 32'd1;

    // counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else cyc_q <= cyc_d;
    end

    assign cyc = cyc_q;
`else
    assign cyc = '0;
`endif
endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: randomized checks of data_memory_mmio against queue/array reference models.
module tb_data_memory_mmio;
    logic clock = 0, reset = 0, en = 0, we = 0, rx_valid = 0, tx_ready = 0;
    logic [31:0] addr = 0, wd = 0;
    logic [7:0] rx_data = 0;
    logic [31:0] rd, rd_inst;
    logic stall, rx_ready, tx_valid;
    logic [7:0] tx_data;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] ref_mem [int];
    logic [7:0] rx_model [$];
    logic [7:0] tx_model [$];
    logic [7:0] tx_got [$];

    always #5 clock = ~clock;

    data_memory_mmio dut (
        .clock(clock), .reset(reset), .en(en), .we(we), .addr(addr), .wd(wd),
        .rd(rd), .rd_inst(rd_inst), .stall(stall),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always @(negedge clock) if (tx_valid && tx_ready) tx_got.push_back(tx_data);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // issue one request, hold it while stall is high, return stall count, rd as stall falls and rd after completion
    task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic [31:0] rd_fall, output logic [31:0] rd_after);
        en = 1; we = w; addr = a; wd = d; stalls = 0;
        #3;
        while (stall && stalls < 100) begin
            stalls++;
            @(posedge clock); #3;
        end
        rd_fall = rd;
        @(posedge clock); #1;
        en = 0; we = 0;
        rd_after = rd;
        @(posedge clock); #1;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && tx_got.size() < n; i++) @(posedge clock);
        #1 tx_ready = 0;
    endtask

    task automatic test_reset;
        en = 1; we = 0; addr = 32'h8000_0000;
        repeat (2) @(posedge clock); #2;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", rd); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        addr = 32'h8000_0002; #1;
        n_cmp++; if (rd_inst !== 32'h2) begin n_bad++; $display("FAIL reset_status: got %h want 2", rd_inst); end
        addr = 32'h8000_0003; reset = 1; #1;
        n_cmp++; if (rd_inst !== 32'h0) begin n_bad++; $display("FAIL reset_counter: got %h want 0", rd_inst); end
        en = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_ram;
        int s, a;
        logic [31:0] rf, ra, d;
        int idx [$];
        do_op(1, 32'd5, 32'h1234_5678, s, rf, ra);
        ref_mem[5] = 32'h1234_5678;
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL ram_wr_stall: got %0d want 0", s); end
        do_op(0, 32'd5, 32'h0, s, rf, ra);
        n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL ram_rd_stall: got %0d want 1", s); end
        n_cmp++; if (rf !== ref_mem[5]) begin n_bad++; $display("FAIL ram_rd_fall: got %h want %h", rf, ref_mem[5]); end
        n_cmp++; if (ra !== ref_mem[5]) begin n_bad++; $display("FAIL ram_rd_hold: got %h want %h", ra, ref_mem[5]); end
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(6, 65535); d = $urandom;
            do_op(1, a, d, s, rf, ra);
            ref_mem[a] = d; idx.push_back(a);
            n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL ram_rand_wr_stall: got %0d want 0", s); end
        end
        for (int i = 0; i < 12; i++) begin
            a = idx[$urandom_range(0, idx.size() - 1)];
            d = {1'b0, 15'($urandom), 16'(a)};
            do_op(0, d, 32'h0, s, rf, ra);
            n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL ram_rand_rd_stall: got %0d want 1", s); end
            n_cmp++; if (rf !== ref_mem[a]) begin n_bad++; $display("FAIL ram_rand_rd: addr %h got %h want %h", d, rf, ref_mem[a]); end
        end
    endtask

    task automatic test_rx_wait;
        int s, dly;
        logic [31:0] rf, ra;
        dly = 4;
        fork
            do_op(0, 32'h8000_0000, 32'h0, s, rf, ra);
            begin
                repeat (dly) @(posedge clock);
                #1 rx_data = 8'hA5; rx_valid = 1;
                @(posedge clock); #1 rx_valid = 0;
            end
        join
        n_cmp++; if (s !== dly + 2) begin n_bad++; $display("FAIL rx_wait_stall: got %0d want %0d", s, dly + 2); end
        n_cmp++; if (rf !== 32'h0000_00A5) begin n_bad++; $display("FAIL rx_wait_rd: got %h want a5", rf); end
        n_cmp++; if (ra !== 32'h0000_00A5) begin n_bad++; $display("FAIL rx_wait_rd_hold: got %h want a5", ra); end
        en = 1; addr = 32'h8000_0002; #2;
        n_cmp++; if (rd_inst !== 32'h2) begin n_bad++; $display("FAIL rx_wait_empty_after: got %h want 2", rd_inst); end
        en = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_tx_full;
        int s, dly;
        logic [31:0] rf, ra, d;
        logic [7:0] g;
        dly = 3; tx_ready = 0; tx_model.delete(); tx_got.delete();
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_op(1, 32'h8000_0001, d, s, rf, ra);
            tx_model.push_back(d[7:0]);
            n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL tx_fill_stall: entry %0d got %0d want 0", i, s); end
        end
        fork
            do_op(1, 32'h8000_0001, 32'hFFFF_FF33, s, rf, ra);
            begin repeat (dly) @(posedge clock); #1 tx_ready = 1; end
        join
        tx_model.push_back(8'h33);
        n_cmp++; if (s !== dly + 2) begin n_bad++; $display("FAIL tx_wait_stall: got %0d want %0d", s, dly + 2); end
        wait_tx(17);
        n_cmp++; if (tx_got.size() !== 17) begin n_bad++; $display("FAIL tx_full_count: got %0d want 17", tx_got.size()); end
        for (int i = 0; i < tx_model.size(); i++) begin
            g = i < tx_got.size() ? tx_got[i] : 8'hxx;
            n_cmp++; if (g !== tx_model[i]) begin n_bad++; $display("FAIL tx_full_order: byte %0d got %h want %h", i, g, tx_model[i]); end
        end
    endtask

    task automatic test_status;
        int s;
        logic [31:0] rf, ra, d;
        logic [7:0] g;
        tx_ready = 0; tx_model.delete(); tx_got.delete();
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_op(1, 32'h8000_0001, d, s, rf, ra);
            tx_model.push_back(d[7:0]);
        end
        rx_data = 8'($urandom); rx_valid = 1; rx_model.push_back(rx_data);
        @(posedge clock); #1 rx_valid = 0;
        en = 1; we = 0; addr = 32'h8000_0002; #2;
        n_cmp++; if (rd_inst !== 32'h1) begin n_bad++; $display("FAIL status_full: got %h want 1", rd_inst); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL status_stall: got %b want 0", stall); end
        addr = 32'h8000_0001; #1;
        n_cmp++; if (rd_inst !== 32'h0) begin n_bad++; $display("FAIL tx_addr_read: got %h want 0", rd_inst); end
        addr = 32'h8ABC_DEF2; #1;
        n_cmp++; if (rd_inst !== 32'h1) begin n_bad++; $display("FAIL status_alias: got %h want 1", rd_inst); end
        we = 1; wd = $urandom; addr = 32'h8000_0002; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL status_wr_stall: got %b want 0", stall); end
        @(posedge clock); #1 addr = 32'h8000_0003;
        @(posedge clock); #1 addr = 32'h8000_0000;
        @(posedge clock); #1 en = 0; we = 0;
        @(posedge clock); #1;
        do_op(0, 32'h8000_0000, 32'h0, s, rf, ra);
        d = {24'b0, rx_model.pop_front()};
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL rx_nowait_stall: got %0d want 0", s); end
        n_cmp++; if (ra !== d) begin n_bad++; $display("FAIL rx_nowait_rd: got %h want %h", ra, d); end
        tx_ready = 1;
        wait_tx(16);
        n_cmp++; if (tx_got.size() !== 16) begin n_bad++; $display("FAIL status_tx_count: got %0d want 16", tx_got.size()); end
        for (int i = 0; i < tx_model.size(); i++) begin
            g = i < tx_got.size() ? tx_got[i] : 8'hxx;
            n_cmp++; if (g !== tx_model[i]) begin n_bad++; $display("FAIL status_tx_order: byte %0d got %h want %h", i, g, tx_model[i]); end
        end
        en = 1; addr = 32'h8000_0002; #2;
        n_cmp++; if (rd_inst !== 32'h2) begin n_bad++; $display("FAIL status_drained: got %h want 2", rd_inst); end
        en = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_rx_random;
        int s;
        logic [31:0] rf, ra, d;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL rx_ready_fill: entry %0d got %b want 1", i, rx_ready); end
            rx_data = 8'($urandom); rx_valid = 1; rx_model.push_back(rx_data);
            @(posedge clock); #1 rx_valid = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rx_ready_full: got %b want 0", rx_ready); end
        rx_data = 8'hEE; rx_valid = 1;
        @(posedge clock); #1 rx_valid = 0;
        for (int i = 0; i < 16; i++) begin
            do_op(0, 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC), 32'h0, s, rf, ra);
            d = {24'b0, rx_model.pop_front()};
            n_cmp++; if (ra !== d || s !== 0) begin n_bad++; $display("FAIL rx_rand_rd: entry %0d got %h/%0d want %h/0", i, ra, s, d); end
        end
        en = 1; addr = 32'h8000_0002; #2;
        n_cmp++; if (rd_inst !== 32'h2) begin n_bad++; $display("FAIL rx_overflow_dropped: got %h want 2", rd_inst); end
        en = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int s, stalled;
        logic [31:0] rf, ra, d;
        logic [7:0] g;
        bit done;
        tx_model.delete(); tx_got.delete(); done = 0; stalled = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    d = $urandom;
                    do_op(1, 32'h8000_0001, d, s, rf, ra);
                    tx_model.push_back(d[7:0]); stalled += s;
                end
                done = 1;
            end
            while (!done) begin
                tx_ready = $urandom_range(0, 7) == 0;
                @(posedge clock); #1;
            end
        join
        n_cmp++; if (stalled == 0) begin n_bad++; $display("FAIL b2b_tx_backpressure: got %0d stall cycles want >0", stalled); end
        tx_ready = 1;
        wait_tx(40);
        n_cmp++; if (tx_got.size() !== 40) begin n_bad++; $display("FAIL b2b_tx_count: got %0d want 40", tx_got.size()); end
        for (int i = 0; i < tx_model.size(); i++) begin
            g = i < tx_got.size() ? tx_got[i] : 8'hxx;
            n_cmp++; if (g !== tx_model[i]) begin n_bad++; $display("FAIL b2b_tx_order: byte %0d got %h want %h", i, g, tx_model[i]); end
        end
        done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    do_op(0, 32'h8000_0000, 32'h0, s, rf, ra);
                    d = rx_model.size() != 0 ? {24'b0, rx_model.pop_front()} : 32'hxxxx_xxxx;
                    n_cmp++; if (ra !== d) begin n_bad++; $display("FAIL b2b_rx: read %0d got %h want %h", i, ra, d); end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    rx_valid = $urandom_range(0, 1) == 1; rx_data = 8'($urandom);
                    if (rx_valid && rx_ready) rx_model.push_back(rx_data);
                    @(posedge clock); #1;
                end
                rx_valid = 0;
            end
        join
        while (rx_model.size() != 0) begin
            do_op(0, 32'h8000_0000, 32'h0, s, rf, ra);
            d = {24'b0, rx_model.pop_front()};
            n_cmp++; if (ra !== d) begin n_bad++; $display("FAIL b2b_rx_drain: got %h want %h", ra, d); end
        end
    endtask

    task automatic test_reset_mid_wait;
        int s;
        logic [31:0] rf, ra;
        en = 1; we = 0; addr = 32'h8000_0000;
        repeat (3) @(posedge clock); #2;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL abort_pre_stall: got %b want 1", stall); end
        n_cmp++; if (rd === 32'h0) begin n_bad++; $display("FAIL abort_pre_rd: got %h want nonzero", rd); end
        reset = 0; #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL abort_stall: got %b want 0", stall); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_rd: got %h want 0", rd); end
        en = 0;
        @(posedge clock); #1 reset = 1;
        rx_model.delete(); tx_model.delete();
        rx_data = 8'h5C; rx_valid = 1;
        @(posedge clock); #1 rx_valid = 0;
        en = 1; addr = 32'h8000_0002; #2;
        n_cmp++; if (rd_inst !== 32'h3) begin n_bad++; $display("FAIL abort_idle_status: got %h want 3", rd_inst); end
        en = 0;
        @(posedge clock); #1;
        do_op(0, 32'd5, 32'h0, s, rf, ra);
        n_cmp++; if (rf !== 32'h1234_5678 || s !== 1) begin n_bad++; $display("FAIL abort_ram_kept: got %h/%0d want 12345678/1", rf, s); end
        do_op(0, 32'h8000_0000, 32'h0, s, rf, ra);
        n_cmp++; if (ra !== 32'h5C) begin n_bad++; $display("FAIL abort_rx_after: got %h want 5c", ra); end
    endtask

    task automatic test_counter;
        logic [31:0] c0, c1;
        en = 1; we = 0; addr = 32'h8000_0003; #2;
        c0 = rd_inst;
        repeat (10) @(posedge clock); #2;
        c1 = rd_inst;
`ifdef MMIO_CYCLE_COUNTER_EN
        n_cmp++; if (c1 - c0 !== 32'd10) begin n_bad++; $display("FAIL counter_delta: got %0d want 10", c1 - c0); end
`else
        n_cmp++; if (c0 !== 32'h0 || c1 !== 32'h0) begin n_bad++; $display("FAIL counter_absent: got %h/%h want 0/0", c0, c1); end
`endif
        en = 0;
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset;
        test_ram;
        test_rx_wait;
        test_tx_full;
        test_status;
        test_rx_random;
        test_back_to_back;
        test_reset_mid_wait;
        test_counter;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
